// File: rtl/rr_mux_arb_nx1_if.sv
// Handshake/bus bundle for rr_mux_arb_nx1: N producer channels in, one consumer out.
// Valid/ready: a beat moves on any cycle where valid and ready are both high at the rising clock edge.
interface rr_mux_arb_nx1_if #(
  parameter int WIDTH = 6,
  parameter int N     = 4
) ();
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_ch;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_mux_arb_nx1.sv
// N-to-1 mux with a fixed-select or round-robin grant and a one-entry registered output stage.
// Once a beat is held and the consumer stalls, every producer sees in_ready low until it drains.
module rr_mux_arb_nx1 #(
  parameter int WIDTH = 6,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arb_nx1_if.slave    bus,
  output logic               dbg_state_o
);
  localparam int SELW = $clog2(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;
  logic [SELW-1:0]  last_grant_q;

  logic [N-1:0]     grant;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  int               c;

  // Grant looks only at current inputs; the round-robin search starts just past the last winner.
  always_comb begin
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    c          = 0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (SELW'(i) == bus.sel && bus.in_valid[i]) begin
          grant[i]   = 1'b1;
          grant_any  = 1'b1;
          grant_idx  = SELW'(i);
          grant_data = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (int'(last_grant_q) + k) % N;
        if (!grant_any && bus.in_valid[c]) begin
          grant[c]   = 1'b1;
          grant_any  = 1'b1;
          grant_idx  = SELW'(c);
          grant_data = bus.in_data[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign load         = grant_any && (state_q == EMPTY || bus.out_ready);
  assign bus.in_ready = load ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      ch_q         <= '0;
      last_grant_q <= SELW'(N - 1);
    end else if (load) begin
      state_q      <= FULL;
      data_q       <= grant_data;
      ch_q         <= grant_idx;
      last_grant_q <= grant_idx;
    end else if (state_q == FULL && bus.out_ready) begin
      state_q <= EMPTY;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_rr_mux_arb_nx1.sv
// Directed bench: default 4x6 instance plus a 3x32 instance for the non-power-of-two case.
module tb_rr_mux_arb_nx1;
  logic clk;
  logic rst;
  logic dbg_a;
  logic dbg_b;
  int   checks;
  int   errors;

  rr_mux_arb_nx1_if #(.WIDTH(6),  .N(4)) a ();
  rr_mux_arb_nx1_if #(.WIDTH(32), .N(3)) b ();

  rr_mux_arb_nx1 #(.WIDTH(6), .N(4)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave), .dbg_state_o(dbg_a)
  );
  rr_mux_arb_nx1 #(.WIDTH(32), .N(3)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave), .dbg_state_o(dbg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.in_data = '0; a.in_valid = '0; a.mode = 1'b0; a.sel = '0; a.out_ready = 1'b0;
    b.in_data = '0; b.in_valid = '0; b.mode = 1'b0; b.sel = '0; b.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a.out_valid !== 1'b0 || a.out_data !== 6'h00 || a.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ch=%0d required 0/00/0", a.out_valid, a.out_data, a.out_ch);
    end
    a.mode = 1'b1; a.in_valid = 4'b0001; a.in_data[0 +: 6] = 6'h15; a.out_ready = 1'b0;
    step();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 6'h15) begin
      errors++;
      $display("FAIL reset_preload: valid=%b data=%h required 1/15", a.out_valid, a.out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.out_data !== 6'h00 || a.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h ch=%0d required 0/00/0", a.out_valid, a.out_data, a.out_ch);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_ch !== 2'd0 || a.out_data !== 6'h15) begin
      errors++;
      $display("FAIL reset_first_rr: valid=%b ch=%0d data=%h required 1/0/15", a.out_valid, a.out_ch, a.out_data);
    end
  endtask

  task automatic test_fixed_select();
    do_reset();
    a.mode = 1'b0; a.sel = 2'd2; a.in_valid = 4'b1111; a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a.in_data[i*6 +: 6] = 6'(i + 1);
    #1;
    checks++;
    if (a.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_in_ready: got %b required 0100", a.in_ready);
    end
    step();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 6'h03 || a.out_ch !== 2'd2) begin
      errors++;
      $display("FAIL fixed_out: valid=%b data=%h ch=%0d required 1/03/2", a.out_valid, a.out_data, a.out_ch);
    end
    a.in_valid = 4'b1011;
    #1;
    checks++;
    if (a.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_no_grant: in_ready=%b required 0000", a.in_ready);
    end
    step();
    checks++;
    if (a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_drain: out_valid=%b required 0", a.out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_all [5];
    logic [1:0] exp_odd [4];
    exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    a.mode = 1'b1; a.in_valid = 4'b1111; a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a.in_data[i*6 +: 6] = 6'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (a.out_valid !== 1'b1 || a.out_ch !== exp_all[k] || a.out_data !== 6'(8'h10 + exp_all[k])) begin
        errors++;
        $display("FAIL rr_all[%0d]: valid=%b ch=%0d data=%h required 1/%0d/%h",
                 k, a.out_valid, a.out_ch, a.out_data, exp_all[k], 6'(8'h10 + exp_all[k]));
      end
    end
    a.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (a.out_valid !== 1'b1 || a.out_ch !== exp_odd[k]) begin
        errors++;
        $display("FAIL rr_1010[%0d]: valid=%b ch=%0d required 1/%0d", k, a.out_valid, a.out_ch, exp_odd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a.mode = 1'b0; a.sel = 2'd1; a.in_valid = 4'b0010; a.in_data[6 +: 6] = 6'h2A; a.out_ready = 1'b0;
    step();
    a.in_data[6 +: 6] = 6'h11;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (a.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b required 0000", k, a.in_ready);
      end
      step();
      checks++;
      if (a.out_valid !== 1'b1 || a.out_data !== 6'h2A || a.out_ch !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d required 1/2a/1", k, a.out_valid, a.out_data, a.out_ch);
      end
    end
    a.out_ready = 1'b1;
    #1;
    checks++;
    if (a.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b required 0010", a.in_ready);
    end
    step();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 6'h11) begin
      errors++;
      $display("FAIL b2b_next: valid=%b data=%h required 1/11", a.out_valid, a.out_data);
    end
    a.in_valid = 4'b0000;
    step();
    checks++;
    if (a.out_valid !== 1'b0 || dbg_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b state=%b required 0/0", a.out_valid, dbg_a);
    end
  endtask

  task automatic test_param();
    logic [1:0] exp_ch [3];
    exp_ch = '{2'd0, 2'd2, 2'd0};
    do_reset();
    b.mode = 1'b0; b.sel = 2'd3; b.in_valid = 3'b111; b.out_ready = 1'b1;
    b.in_data[0 +: 32] = 32'hDEADBEEF; b.in_data[32 +: 32] = 32'h0BADF00D; b.in_data[64 +: 32] = 32'h12345678;
    #1;
    checks++;
    if (b.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL n3_sel_oob_ready: got %b required 000", b.in_ready);
    end
    step();
    checks++;
    if (b.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL n3_sel_oob_valid: got %b required 0", b.out_valid);
    end
    b.mode = 1'b1; b.in_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (b.out_valid !== 1'b1 || b.out_ch !== exp_ch[k] ||
          b.out_data !== (exp_ch[k] == 2'd0 ? 32'hDEADBEEF : 32'h12345678)) begin
        errors++;
        $display("FAIL n3_rr[%0d]: valid=%b ch=%0d data=%h required 1/%0d", k, b.out_valid, b.out_ch, b.out_data, exp_ch[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_back_to_back();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
